// File: rtl/fetch_unit.sv
// Stage-I fetch front end: owns the PC, drives the synchronous I-cache and
// pipelines the fetch PC toward the X and M stages.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h4000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  PC_Sel,
   input  logic [31:0] ALU_Out,
   input  logic        Inst_Kill,
   input  logic        fetch_stall,
   output logic [31:0] icache_addr,
   output logic        icache_re,
   input  logic [31:0] icache_dout,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] PC_I,
   output logic [31:0] PC_X,
   output logic [31:0] PC4_M
);

   localparam logic [1:0] PCSEL_ALU = 2'd1;

   logic [31:0] pcI_q, pcI_d;
   logic        boot_q;
   logic        pendV_q, pendV_d;
   logic [31:0] pendTgt_q, pendTgt_d;
   logic [31:0] pcX_q, pcX_d;
   logic [31:0] pc4M_q;

   logic        redir;
   logic [31:0] tgt;

   assign redir = (PC_Sel == PCSEL_ALU);
   assign tgt   = {ALU_Out[31:1], 1'b0};

   // A stall freezes the PC; a redirect arriving during a stall is parked
   // and replayed on the first unstalled cycle, ahead of any new redirect.
   always_comb begin
      pcI_d     = pcI_q + 32'd4;
      pendV_d   = pendV_q;
      pendTgt_d = pendTgt_q;
      if (!boot_q || fetch_stall) begin
         pcI_d = pcI_q;
      end else if (pendV_q) begin
         pcI_d = pendTgt_q;
      end else if (redir) begin
         pcI_d = tgt;
      end
      if (fetch_stall) begin
         if (redir) begin
            pendV_d   = 1'b1;
            pendTgt_d = tgt;
         end
      end else begin
         pendV_d = 1'b0;
      end
   end

   always_comb begin
      inst       = icache_dout;
      inst_valid = 1'b1;
      if (!boot_q || fetch_stall || Inst_Kill || pendV_q) begin
         inst       = NOP_INST;
         inst_valid = 1'b0;
      end
      pcX_d = pcX_q;
      if (!fetch_stall && inst_valid) begin
         pcX_d = pcI_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcI_q     <= RESET_PC;
         boot_q    <= 1'b0;
         pendV_q   <= 1'b0;
         pendTgt_q <= 32'd0;
         pcX_q     <= 32'd0;
         pc4M_q    <= 32'd0;
      end else begin
         pcI_q     <= pcI_d;
         boot_q    <= 1'b1;
         pendV_q   <= pendV_d;
         pendTgt_q <= pendTgt_d;
         pcX_q     <= pcX_d;
         pc4M_q    <= pcX_q + 32'd4;
      end
   end

   // Reads stay enabled until the first real fetch so the reset word is primed.
   assign icache_re   = ~fetch_stall | ~boot_q;
   assign icache_addr = pcI_d;
   assign PC_I        = pcI_q;
   assign PC_X        = pcX_q;
   assign PC4_M       = pc4M_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency I-cache model.
module tb_fetch_unit;

   localparam logic [31:0] RST = 32'h4000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [1:0]  PC_Sel;
   logic [31:0] ALU_Out;
   logic        Inst_Kill;
   logic        fetch_stall;
   logic [31:0] icache_addr;
   logic        icache_re;
   logic [31:0] icache_dout;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] PC_I;
   logic [31:0] PC_X;
   logic [31:0] PC4_M;

   int vecCount  = 0;
   int missCount = 0;

   fetch_unit dut (
      .clk(clk), .reset(reset), .PC_Sel(PC_Sel), .ALU_Out(ALU_Out),
      .Inst_Kill(Inst_Kill), .fetch_stall(fetch_stall),
      .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
      .inst(inst), .inst_valid(inst_valid), .PC_I(PC_I), .PC_X(PC_X), .PC4_M(PC4_M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Synchronous BRAM model: output holds while read enable is low.
   initial icache_dout = 32'd0;
   always @(posedge clk) begin
      if (icache_re) icache_dout <= memWord(icache_addr);
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] alu,
                                input logic kill, input logic stall);
      @(posedge clk);
      #1;
      PC_Sel      = sel;
      ALU_Out     = alu;
      Inst_Kill   = kill;
      fetch_stall = stall;
      #1;
   endtask

   task automatic checkFetch(input string tag, input logic [31:0] pc,
                             input logic [31:0] addr, input logic valid);
      checkOutput({tag, ".pcI"}, PC_I, pc);
      checkOutput({tag, ".addr"}, icache_addr, addr);
      checkOutput({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, valid});
      checkOutput({tag, ".inst"}, inst, valid ? memWord(pc) : NOP);
   endtask

   initial begin
      reset = 1'b0; PC_Sel = 2'd0; ALU_Out = 32'd0; Inst_Kill = 1'b0; fetch_stall = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst.inst", inst, NOP);
      checkOutput("rst.valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("rst.re", {31'd0, icache_re}, 32'd1);
      checkOutput("rst.addr", icache_addr, RST);
      checkOutput("rst.pcX", PC_X, 32'd0);
      checkOutput("rst.pc4M", PC4_M, 32'd0);

      // Reset release and straight-line fetch
      @(posedge clk); #1; reset = 1'b1; #1;
      checkOutput("c0.valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("c0.addr", icache_addr, RST);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      checkFetch("c1", RST, RST + 4, 1'b1);
      checkOutput("c1.pcX", PC_X, 32'd0);
      checkOutput("c1.pc4M", PC4_M, 32'd4);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      checkFetch("c2", RST + 4, RST + 8, 1'b1);
      checkOutput("c2.pcX", PC_X, RST);
      checkOutput("c2.pc4M", PC4_M, 32'd4);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      checkFetch("c3", RST + 8, RST + 12, 1'b1);
      checkOutput("c3.pcX", PC_X, RST + 4);
      checkOutput("c3.pc4M", PC4_M, RST + 4);

      // Taken redirect with kill, target bit 0 cleared
      applyStimulus(2'd1, 32'h4000_0101, 1'b1, 1'b0);
      checkOutput("redir.inst", inst, NOP);
      checkOutput("redir.valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("redir.addr", icache_addr, 32'h4000_0100);
      checkOutput("redir.pcX", PC_X, RST + 8);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      checkFetch("tgt", 32'h4000_0100, 32'h4000_0104, 1'b1);
      checkOutput("tgt.pcX", PC_X, RST + 8);
      checkOutput("tgt.pc4M", PC4_M, RST + 12);

      // Three-cycle stall: PC frozen, X/M drain
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2'd0, 32'd0, 1'b0, 1'b1);
         checkFetch("stall", 32'h4000_0104, 32'h4000_0104, 1'b0);
         checkOutput("stall.re", {31'd0, icache_re}, 32'd0);
         checkOutput("stall.pcX", PC_X, 32'h4000_0100);
         if (i > 0) checkOutput("stall.pc4M", PC4_M, 32'h4000_0104);
      end
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      checkFetch("unstall", 32'h4000_0104, 32'h4000_0108, 1'b1);
      checkOutput("unstall.re", {31'd0, icache_re}, 32'd1);

      // Two redirects inside one stall: last one wins
      applyStimulus(2'd1, 32'h4000_0200, 1'b0, 1'b1);
      checkFetch("pend1", 32'h4000_0108, 32'h4000_0108, 1'b0);
      applyStimulus(2'd1, 32'h4000_0300, 1'b0, 1'b1);
      checkFetch("pend2", 32'h4000_0108, 32'h4000_0108, 1'b0);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b1);
      checkFetch("pend3", 32'h4000_0108, 32'h4000_0108, 1'b0);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      checkFetch("release", 32'h4000_0108, 32'h4000_0300, 1'b0);
      checkOutput("release.re", {31'd0, icache_re}, 32'd1);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      checkFetch("pendTgt", 32'h4000_0300, 32'h4000_0304, 1'b1);

      // Wrap at the top of the address space, and kill without redirect
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      applyStimulus(2'd1, 32'hFFFF_FFFD, 1'b1, 1'b0);
      checkOutput("wrapRedir.addr", icache_addr, 32'hFFFF_FFFC);
      applyStimulus(2'd0, 32'd0, 1'b1, 1'b0);
      checkFetch("killOnly", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      checkFetch("wrapped", 32'h0000_0000, 32'h0000_0004, 1'b1);

      // Reset asserted mid-stall with a parked redirect
      applyStimulus(2'd1, 32'h4000_0500, 1'b0, 1'b1);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b1);
      reset = 1'b0;
      #1;
      checkOutput("midRst.inst", inst, NOP);
      checkOutput("midRst.valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("midRst.re", {31'd0, icache_re}, 32'd1);
      checkOutput("midRst.addr", icache_addr, RST);
      checkOutput("midRst.pcI", PC_I, RST);
      checkOutput("midRst.pcX", PC_X, 32'd0);
      checkOutput("midRst.pc4M", PC4_M, 32'd0);
      fetch_stall = 1'b0;
      @(posedge clk); #1; reset = 1'b1; #1;
      checkOutput("rst2.c0.valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("rst2.c0.addr", icache_addr, RST);
      applyStimulus(2'd0, 32'd0, 1'b0, 1'b0);
      checkFetch("rst2.c1", RST, RST + 4, 1'b1);

      // Reserved PC_Sel encoding behaves as PLUS4
      applyStimulus(2'd2, 32'h4000_0800, 1'b0, 1'b0);
      checkFetch("sel2", RST + 4, RST + 8, 1'b1);
      applyStimulus(2'd3, 32'h4000_0900, 1'b0, 1'b0);
      checkFetch("sel3", RST + 8, RST + 12, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
